fir_decim: RTL and testbench

Decimating serial-MAC FIR filter: the audio low-pass/decimation stage that sits directly upstream of the de-emphasis IIR in the FM audio path. It accepts fixed-point demodulator samples over a valid/ready handshake, keeps a TAPS-deep sample history, and computes one filtered output for every DECIM accepted inputs. Each output is presented to the IIR stage over a valid/ready handshake. Arithmetic uses the codebase's Q-format: signed fixed point with FRAC_BITS fractional bits, and every product is dequantized individually.

---
 rtl/fir_decim.sv | 151 +++++++++++++++
 tb/tb_fir_decim.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim.sv
// fir_decim: decimating serial-MAC FIR filter.
// Keeps a TAPS-deep sample history and, after every DECIM accepted samples,
// walks the taps one per cycle through a single multiplier, then holds the
// result on a valid/ready output until the downstream stage takes it.
`timescale 1ns/1ps
module fir_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 20,
    parameter int DECIM      = 8,
    parameter int FRAC_BITS  = 10,
    // Entry i (bits i*DATA_WIDTH +: DATA_WIDTH) multiplies the sample i positions old
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFFS =
        {TAPS{DATA_WIDTH'((1 << FRAC_BITS) / TAPS)}}
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   x_q     [TAPS];
    logic signed [DATA_WIDTH-1:0]   x_d     [TAPS];
    logic signed [DATA_WIDTH-1:0]   x_shift [TAPS];
    logic signed [DATA_WIDTH-1:0]   coef    [TAPS];
    logic [CW-1:0]                  dcnt_q, dcnt_d;
    logic [KW-1:0]                  k_q, k_d;
    logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           in_ready_q, in_ready_d;

    logic signed [DATA_WIDTH-1:0]   x_sel, c_sel;
    logic signed [2*DATA_WIDTH-1:0] x_ext, c_ext, prod;
    logic signed [DATA_WIDTH-1:0]   term, acc_sum;

    // Unpack the flat coefficient parameter and build the shifted history.
    assign x_shift[0] = in_data;
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
            assign coef[gi] = COEFFS[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (genvar gi = 1; gi < TAPS; gi++) begin : g_shift
            assign x_shift[gi] = x_q[gi-1];
        end
    endgenerate

    // One product per cycle: full-width signed multiply, shift out the
    // fractional bits, keep the low DATA_WIDTH bits.
    assign x_sel   = x_q[k_q];
    assign c_sel   = coef[k_q];
    assign x_ext   = {{DATA_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
    assign c_ext   = {{DATA_WIDTH{c_sel[DATA_WIDTH-1]}}, c_sel};
    assign prod    = x_ext * c_ext;
    assign term    = DATA_WIDTH'(prod >>> FRAC_BITS);
    assign acc_sum = ((k_q == '0) ? '0 : acc_q) + term;

    // Handshake outputs come straight from registers; reset masks in_ready.
    assign in_ready  = in_ready_q & reset;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state logic for the IDLE -> MAC -> OUT sequence.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        dcnt_d      = dcnt_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d = x_shift;
                    if (dcnt_q == D_LAST) begin
                        dcnt_d     = '0;
                        state_d    = S_MAC;
                        in_ready_d = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + CW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (k_q == K_LAST) begin
                    k_d         = '0;
                    out_data_d  = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
            dcnt_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            dcnt_q      <= dcnt_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim: scoreboard bench for fir_decim.
// Instance A: TAPS=4, DECIM=2, coeffs {1024,2048,3072,4096}.
// Instance B: default parameters. Instance C: TAPS=4, DECIM=2, coeffs {1,0,0,0}.
`timescale 1ns/1ps
module tb_fir_decim;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic signed [31:0] a_in_data = '0, b_in_data = '0, c_in_data = '0;
    logic a_in_valid = 1'b0, b_in_valid = 1'b0, c_in_valid = 1'b0;
    logic a_out_ready = 1'b1, b_out_ready = 1'b1, c_out_ready = 1'b1;
    logic a_in_ready, b_in_ready, c_in_ready;
    logic a_out_valid, b_out_valid, c_out_valid;
    logic signed [31:0] a_out_data, b_out_data, c_out_data;

    fir_decim #(.DATA_WIDTH(32), .TAPS(4), .DECIM(2), .FRAC_BITS(10),
                .COEFFS({32'd4096, 32'd3072, 32'd2048, 32'd1024})) dut_a (
        .clock(clock), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready));

    fir_decim dut_b (
        .clock(clock), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready));

    fir_decim #(.DATA_WIDTH(32), .TAPS(4), .DECIM(2), .FRAC_BITS(10),
                .COEFFS({32'd0, 32'd0, 32'd0, 32'd1})) dut_c (
        .clock(clock), .reset(reset),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready));

    int n_tests = 0;
    int n_fail  = 0;
    int coef_a[$];
    int coef_b[$];
    int hist_a[$];
    int exp_a[$];
    int got_a[$];
    int dcnt_a  = 0;
    int n_acc_a = 0;
    int n_out_a = 0;
    bit rnd_bp  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: y = sum_k trunc32((x[k] * c[k]) >>> 10), x[k] = k-th newest sample.
    function automatic int ref_out(input int h[$], input int c[$]);
        int acc = 0;
        for (int k = 0; k < c.size(); k++) begin
            longint p;
            p = (k < h.size()) ? longint'(h[k]) * longint'(c[k]) : 64'sd0;
            acc += int'(p >>> 10);
        end
        return acc;
    endfunction

    // Stimulus side of the scoreboard: record accepted samples, push expected outputs.
    always @(negedge clock) begin : stim_mon_a
        if (!reset) begin
            hist_a.delete();
            exp_a.delete();
            dcnt_a = 0;
        end else if (a_in_valid && a_in_ready) begin
            n_acc_a++;
            hist_a.push_front(a_in_data);
            if (hist_a.size() > 4) void'(hist_a.pop_back());
            dcnt_a++;
            if (dcnt_a == 2) begin
                dcnt_a = 0;
                exp_a.push_back(ref_out(hist_a, coef_a));
            end
        end
    end

    // Output monitor: pop and compare on every output handshake.
    always @(negedge clock) begin : out_mon_a
        if (reset && a_out_valid && a_out_ready) begin
            got_a.push_back(a_out_data);
            n_out_a++;
            $display("[TB] A out #%0d = %0d", n_out_a, a_out_data);
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_out: got %0d, expected no output", a_out_data);
            end else begin
                check("a_out", a_out_data, exp_a.pop_front());
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Present one sample to A and return just after the edge that accepts it.
    task automatic a_send(input int v);
        int t = 0;
        a_in_data  = v;
        a_in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (a_in_ready) break;
            t++;
            if (t > 300) begin
                check("a_send_timeout", 0, 1);
                break;
            end
            @(posedge clock); #1;
            if (rnd_bp) a_out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        if (rnd_bp) a_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic a_drain();
        int t = 0;
        while (exp_a.size() > 0 && t < 500) begin
            @(posedge clock); #1;
            t++;
        end
        check("a_drain_empty", exp_a.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic run_impulse(input string tag);
        int vals[6] = '{1024, 0, 0, 0, 0, 0};
        got_a.delete();
        a_out_ready = 1'b1;
        foreach (vals[i]) a_send(vals[i]);
        a_drain();
        check({tag, "_count"}, got_a.size(), 3);
        if (got_a.size() == 3) begin
            check({tag, "_y0"}, got_a[0], 2048);
            check({tag, "_y1"}, got_a[1], 4096);
            check({tag, "_y2"}, got_a[2], 0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int held;
        int acc_before, out_before;
        int hb[$];
        int nacc, t;

        coef_a = {1024, 2048, 3072, 4096};
        for (int i = 0; i < 20; i++) coef_b.push_back(51);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready_low", a_in_ready, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        @(posedge clock); #1;

        // 1. Impulse
        run_impulse("impulse");

        // 2. DC
        pulse_reset();
        got_a.delete();
        repeat (6) a_send(512);
        a_drain();
        check("dc_count", got_a.size(), 3);
        if (got_a.size() == 3) begin
            check("dc_first", got_a[0], 1536);
            check("dc_steady1", got_a[1], 5120);
            check("dc_steady2", got_a[2], 5120);
        end

        // 3a. Negative DC
        pulse_reset();
        got_a.delete();
        repeat (8) a_send(-1024);
        a_drain();
        check("neg_count", got_a.size(), 4);
        if (got_a.size() == 4) begin
            check("neg_first", got_a[0], -3072);
            check("neg_steady", got_a[3], -10240);
        end

        // 3b. Arithmetic shift of a tiny negative product
        c_in_data  = -1;
        c_in_valid = 1'b1;
        nacc = 0;
        t = 0;
        while (nacc < 2 && t < 50) begin
            @(negedge clock);
            if (c_in_ready) nacc++;
            @(posedge clock); #1;
            t++;
        end
        c_in_valid = 1'b0;
        check("c_accepts", nacc, 2);
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!c_out_valid && t < 50);
        check("c_out_valid", c_out_valid, 1);
        check("c_neg_one", c_out_data, -1);
        $display("[TB] C out = %0d", c_out_data);
        @(posedge clock); #1;

        // 4. Backpressure
        pulse_reset();
        a_out_ready = 1'b0;
        a_send(int'($urandom_range(0, 200000)) - 100000);
        a_send(int'($urandom_range(0, 200000)) - 100000);
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!a_out_valid && t < 50);
        check("bp_valid_rise", a_out_valid, 1);
        held = a_out_data;
        acc_before = n_acc_a;
        @(posedge clock); #1;
        a_in_data  = 77;
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_valid_held", a_out_valid, 1);
            check("bp_data_held", a_out_data, held);
            check("bp_in_ready_low", a_in_ready, 0);
            @(posedge clock); #1;
        end
        out_before  = n_out_a;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("bp_one_transfer", n_out_a, out_before + 1);
        check("bp_no_accept", n_acc_a, acc_before);
        check("bp_valid_drop", a_out_valid, 0);
        check("bp_in_ready_back", a_in_ready, 1);
        @(posedge clock); #1;

        // 5. Latency with default parameters
        b_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_in_data = int'($urandom_range(0, 2000000)) - 1000000;
            @(negedge clock);
            check("lat_b_in_ready", b_in_ready, 1);
            hb.push_front(b_in_data);
            @(posedge clock); #1;
        end
        b_in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            check("lat_valid_low", b_out_valid, 0);
            check("lat_in_ready_low", b_in_ready, 0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("lat_valid_t21", b_out_valid, 1);
        check("lat_in_ready_t21", b_in_ready, 0);
        check("lat_b_data", b_out_data, ref_out(hb, coef_b));
        $display("[TB] B out = %0d", b_out_data);
        @(posedge clock); #1;

        // Randomized traffic on A with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a_send(int'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        rnd_bp = 1'b0;
        a_out_ready = 1'b1;
        a_drain();

        // 6. Reset two cycles into MAC
        a_send(1000);
        a_send(2000);
        @(posedge clock); #1;
        out_before = n_out_a;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rmac_in_ready", a_in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            check("rmac_valid_low", a_out_valid, 0);
            @(negedge clock);
        end
        check("rmac_no_output", n_out_a, out_before);
        @(posedge clock); #1;
        run_impulse("impulse_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
